// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// The design takes the slave modport; a producer/consumer/ALU takes the master modport.
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int FIFO_CNT_W = $clog2(DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_a;
    logic [3:0]            cmd_b;
    logic [2:0]            cmd_op;
    logic [3:0]            alu_a;
    logic [3:0]            alu_b;
    logic [2:0]            alu_opcode;
    logic                  alu_en;
    logic [4:0]            alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [4:0]            rsp_result;
    logic [2:0]            rsp_op;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0]      rsp_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode, alu_en,
               rsp_valid, rsp_result, rsp_op, fifo_count, rsp_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode, alu_en,
               rsp_valid, rsp_result, rsp_op, fifo_count, rsp_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues each with a one-cycle enable pulse and
// holds the captured 5-bit result on a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  ONE_COUNT  = (PTR_W + 1)'(1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    state_t           r_state;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_alu_en;
    logic             r_rsp_valid;
    logic [4:0]       r_rsp_result;
    logic [2:0]       r_rsp_op;
    logic [CNT_W-1:0] r_rsp_count;

    state_t w_next_state;
    logic   w_push;
    logic   w_pop;
    logic   w_empty;
    logic   w_capture;
    logic   w_rsp_done;
    logic   w_alu_en_next;
    logic   w_rsp_valid_next;
    cmd_t   w_head;

    // Ready comes from the registered count only, so a full FIFO never accepts
    // a push even when the FSM pops on the same edge.
    assign w_push  = bus.cmd_valid && (r_count != FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // NOTE: combinational block uses blocking '=' and assigns every output a
    // default first, so no path leaves a signal unassigned and no latch appears.
    always_comb begin
        w_next_state     = r_state;
        w_pop            = 1'b0;
        w_capture        = 1'b0;
        w_rsp_done       = 1'b0;
        w_alu_en_next    = 1'b0;
        w_rsp_valid_next = r_rsp_valid;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_alu_en_next = 1'b1;
                    w_next_state  = ISSUE;
                end
            end
            ISSUE: begin
                w_capture        = 1'b1;
                w_rsp_valid_next = 1'b1;
                w_next_state     = HOLD;
            end
            HOLD: begin
                w_rsp_valid_next = 1'b1;
                if (bus.rsp_ready) begin
                    w_rsp_done       = 1'b1;
                    w_rsp_valid_next = 1'b0;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_alu_en_next = 1'b1;
                        w_next_state  = ISSUE;
                    end else begin
                        w_next_state  = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; entries are only read after a push
    // has written them, and the reset pointers/count already make it empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
        end
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_rsp_count  <= '0;
        end else begin
            r_alu_en    <= w_alu_en_next;
            r_rsp_valid <= w_rsp_valid_next;
            // Operands stay at their last issued value; only alu_en marks an issue.
            if (w_pop) begin
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
                r_alu_op <= w_head.op;
            end
            if (w_capture) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_op     <= r_alu_op;
            end
            if (w_rsp_done) r_rsp_count <= r_rsp_count + CNT_W'(1);
        end
    end

    assign bus.cmd_ready  = (r_count != FULL_COUNT);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.alu_en     = r_alu_en;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.fifo_count = r_count;
    assign bus.rsp_count  = r_rsp_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table-driven single commands plus
// hand-written sweep, full-FIFO, push-while-pop, mid-HOLD reset and wrap sequences.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [4:0] exp_result;
    } vec_t;

    typedef struct {
        logic [4:0] result;
        logic [2:0] op;
        int         cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   exp_cnt = 0;
    rsp_t rsp_q[$];
    vec_t vecs[10];
    logic [4:0] sweep_exp[8];

    alu_cmd_sequencer_if #(.DEPTH(DEPTH), .CNT_W(8)) if_m ();
    alu_cmd_sequencer_if #(.DEPTH(DEPTH), .CNT_W(2)) if_w ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for ALU_4BIT: add, sub, and, or, xor, not a, a<<1, a>>1; 0 when disabled.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op, input logic en);
        if (!en) return 5'd0;
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {2'b00, a[3:1]};
        endcase
    endfunction

    assign if_m.alu_result = alu_model(if_m.alu_a, if_m.alu_b, if_m.alu_opcode, if_m.alu_en);
    assign if_w.alu_result = alu_model(if_w.alu_a, if_w.alu_b, if_w.alu_opcode, if_w.alu_en);
    assign if_w.cmd_valid  = if_m.cmd_valid;
    assign if_w.cmd_a      = if_m.cmd_a;
    assign if_w.cmd_b      = if_m.cmd_b;
    assign if_w.cmd_op     = if_m.cmd_op;
    assign if_w.rsp_ready  = if_m.rsp_ready;

    always @(negedge clk) begin
        if (rst_n && if_m.rsp_valid && if_m.rsp_ready)
            rsp_q.push_back('{result: if_m.rsp_result, op: if_m.rsp_op, cyc: cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit done = 1'b0;
        if_m.cmd_a     = a;
        if_m.cmd_b     = b;
        if_m.cmd_op    = op;
        if_m.cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (if_m.cmd_ready) done = 1'b1;
            tick();
        end
        if_m.cmd_valid = 1'b0;
        if (!done) timeout_fail("push_accept");
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int i = 0;
        while (rsp_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (rsp_q.size() < n) timeout_fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit clean;

        vecs[0] = '{4'd2,  4'd3,  3'd0, 5'd5};
        vecs[1] = '{4'd15, 4'd1,  3'd0, 5'd16};
        vecs[2] = '{4'd2,  4'd3,  3'd1, 5'd31};
        vecs[3] = '{4'd9,  4'd4,  3'd1, 5'd5};
        vecs[4] = '{4'd12, 4'd10, 3'd2, 5'd8};
        vecs[5] = '{4'd12, 4'd10, 3'd3, 5'd14};
        vecs[6] = '{4'd12, 4'd10, 3'd4, 5'd6};
        vecs[7] = '{4'd5,  4'd0,  3'd5, 5'd10};
        vecs[8] = '{4'd9,  4'd0,  3'd6, 5'd18};
        vecs[9] = '{4'd9,  4'd0,  3'd7, 5'd4};
        sweep_exp = '{5'd5, 5'd31, 5'd2, 5'd3, 5'd1, 5'd13, 5'd4, 5'd1};

        if_m.cmd_valid = 1'b0;
        if_m.cmd_a     = '0;
        if_m.cmd_b     = '0;
        if_m.cmd_op    = '0;
        if_m.rsp_ready = 1'b0;

        // Reset state
        #2;
        check("rst_alu_en",     if_m.alu_en,     0);
        check("rst_rsp_valid",  if_m.rsp_valid,  0);
        check("rst_fifo_count", if_m.fifo_count, 0);
        check("rst_rsp_count",  if_m.rsp_count,  0);
        check("rst_cmd_ready",  if_m.cmd_ready,  1);
        tick();
        tick();
        rst_n = 1'b1;

        // Single-command table: latency, issue pulse, capture and count
        foreach (vecs[i]) begin
            tick();
            if_m.cmd_a     = vecs[i].a;
            if_m.cmd_b     = vecs[i].b;
            if_m.cmd_op    = vecs[i].op;
            if_m.cmd_valid = 1'b1;
            tick();
            if_m.cmd_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_count_k", i),  if_m.fifo_count, 1);
            check($sformatf("v%0d_en_k", i),     if_m.alu_en,     0);
            @(negedge clk);
            check($sformatf("v%0d_en_k1", i),    if_m.alu_en,     1);
            check($sformatf("v%0d_alu_a", i),    if_m.alu_a,      vecs[i].a);
            check($sformatf("v%0d_alu_b", i),    if_m.alu_b,      vecs[i].b);
            check($sformatf("v%0d_alu_op", i),   if_m.alu_opcode, vecs[i].op);
            check($sformatf("v%0d_valid_k1", i), if_m.rsp_valid,  0);
            @(negedge clk);
            check($sformatf("v%0d_valid_k2", i), if_m.rsp_valid,  1);
            check($sformatf("v%0d_en_k2", i),    if_m.alu_en,     0);
            check($sformatf("v%0d_result", i),   if_m.rsp_result, vecs[i].exp_result);
            check($sformatf("v%0d_rsp_op", i),   if_m.rsp_op,     vecs[i].op);
            tick();
            check($sformatf("v%0d_hold", i),     if_m.rsp_valid,  1);
            if_m.rsp_ready = 1'b1;
            tick();
            if_m.rsp_ready = 1'b0;
            exp_cnt++;
            @(negedge clk);
            check($sformatf("v%0d_valid_done", i), if_m.rsp_valid, 0);
            check($sformatf("v%0d_rsp_count", i),  if_m.rsp_count, exp_cnt);
        end
        check("wrap_cnt_after_table", if_w.rsp_count, exp_cnt % 4);

        // Opcode sweep with rsp_ready tied high: order and 2-cycle spacing
        tick();
        rsp_q.delete();
        if_m.rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) push_cmd(4'd2, 4'd3, 3'(op));
        wait_q(8, 60, "sweep_wait");
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            check($sformatf("sweep%0d_op", i),     rsp_q[i].op,     i);
            check($sformatf("sweep%0d_result", i), rsp_q[i].result, sweep_exp[i]);
            if (i > 0) check($sformatf("sweep%0d_spacing", i), rsp_q[i].cyc - rsp_q[i-1].cyc, 2);
        end
        tick();
        tick();
        if_m.rsp_ready = 1'b0;
        exp_cnt += 8;
        check("sweep_rsp_count",  if_m.rsp_count,  exp_cnt);
        check("sweep_fifo_empty", if_m.fifo_count, 0);

        // Full FIFO under backpressure, 6th command stalls, no full bypass
        rsp_q.delete();
        for (int op = 1; op <= 5; op++) push_cmd(4'(op), 4'd2, 3'(op));
        @(negedge clk);
        check("full_count",     if_m.fifo_count, 4);
        check("full_cmd_ready", if_m.cmd_ready,  0);
        check("full_held",      if_m.rsp_valid,  1);
        check("full_held_op",   if_m.rsp_op,     1);
        check("full_held_res",  if_m.rsp_result, 31);
        tick();
        if_m.cmd_a     = 4'd6;
        if_m.cmd_b     = 4'd2;
        if_m.cmd_op    = 3'd6;
        if_m.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_count", i), if_m.fifo_count, 4);
            check($sformatf("stall%0d_ready", i), if_m.cmd_ready,  0);
            tick();
        end
        if_m.rsp_ready = 1'b1;
        tick();
        if_m.rsp_ready = 1'b0;
        @(negedge clk);
        check("nobypass_count", if_m.fifo_count, 3);
        check("nobypass_issue", if_m.alu_en,     1);
        check("nobypass_ready", if_m.cmd_ready,  1);
        tick();
        if_m.cmd_valid = 1'b0;
        @(negedge clk);
        check("sixth_count",  if_m.fifo_count, 4);
        check("sixth_rsp_op", if_m.rsp_op,     2);
        tick();
        if_m.rsp_ready = 1'b1;
        wait_q(6, 60, "full_drain");
        for (int i = 0; i < 6 && i < rsp_q.size(); i++)
            check($sformatf("full%0d_op", i), rsp_q[i].op, i + 1);
        tick();
        tick();
        if_m.rsp_ready = 1'b0;
        exp_cnt += 6;
        check("full_rsp_count", if_m.rsp_count,  exp_cnt);
        check("full_empty",     if_m.fifo_count, 0);

        // Push and HOLD handshake on the same edge with two queued
        rsp_q.delete();
        push_cmd(4'd7, 4'd1, 3'd0);
        push_cmd(4'd8, 4'd1, 3'd2);
        push_cmd(4'd9, 4'd1, 3'd3);
        @(negedge clk);
        check("pwp_pre_count", if_m.fifo_count, 2);
        check("pwp_pre_hold",  if_m.rsp_valid,  1);
        tick();
        if_m.cmd_a     = 4'd10;
        if_m.cmd_b     = 4'd1;
        if_m.cmd_op    = 3'd4;
        if_m.cmd_valid = 1'b1;
        if_m.rsp_ready = 1'b1;
        tick();
        if_m.cmd_valid = 1'b0;
        if_m.rsp_ready = 1'b0;
        @(negedge clk);
        check("pwp_count",     if_m.fifo_count, 2);
        check("pwp_issue",     if_m.alu_en,     1);
        check("pwp_alu_a",     if_m.alu_a,      8);
        check("pwp_alu_op",    if_m.alu_opcode, 2);
        check("pwp_valid_low", if_m.rsp_valid,  0);
        tick();
        if_m.rsp_ready = 1'b1;
        wait_q(4, 40, "pwp_drain");
        if (rsp_q.size() >= 4) begin
            check("pwp0_res", rsp_q[0].result, 8);
            check("pwp1_res", rsp_q[1].result, 0);
            check("pwp2_res", rsp_q[2].result, 9);
            check("pwp3_res", rsp_q[3].result, 11);
            check("pwp3_op",  rsp_q[3].op,     4);
        end
        tick();
        tick();
        if_m.rsp_ready = 1'b0;
        exp_cnt += 4;
        check("pwp_rsp_count", if_m.rsp_count, exp_cnt);

        // Asynchronous reset in HOLD with three queued
        rsp_q.delete();
        for (int i = 0; i < 4; i++) push_cmd(4'd3, 4'd1, 3'(i + 5));
        @(negedge clk);
        check("mid_pre_valid", if_m.rsp_valid,  1);
        check("mid_pre_count", if_m.fifo_count, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  if_m.rsp_valid,  0);
        check("mid_rst_en",     if_m.alu_en,     0);
        check("mid_rst_count",  if_m.fifo_count, 0);
        check("mid_rst_rspcnt", if_m.rsp_count,  0);
        check("mid_rst_alu_a",  if_m.alu_a,      0);
        check("mid_rst_result", if_m.rsp_result, 0);
        check("mid_rst_wrapcnt", if_w.rsp_count, 0);
        tick();
        rst_n = 1'b1;
        if_m.rsp_ready = 1'b1;
        clean = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_m.rsp_valid || if_m.alu_en) clean = 1'b0;
        end
        check("mid_no_stale", clean, 1);
        check("mid_no_rsp",   rsp_q.size(), 0);
        exp_cnt = 0;

        // Five responses: 8-bit counter reads 5, 2-bit counter wraps to 1
        tick();
        for (int i = 0; i < 5; i++) push_cmd(4'(i), 4'd1, 3'(i));
        wait_q(5, 40, "wrap_wait");
        tick();
        tick();
        if_m.rsp_ready = 1'b0;
        check("wrap_cnt2", if_w.rsp_count, 1);
        check("wrap_cnt8", if_m.rsp_count, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
